// File: rtl/turf_hold_buffer_scheduler_pkg.sv
// turf_hold_buffer_scheduler_pkg: FSM encodings, counter width and saturating increment
package turf_hold_buffer_scheduler_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, SETTLE = 2'd2} state_t;
   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/turf_hold_buffer_scheduler_if.sv
// turf_hold_buffer_scheduler_if: trigger/clear requests and HOLD/occupancy status bundle
interface turf_hold_buffer_scheduler_if
   import turf_hold_buffer_scheduler_pkg::*;
   #(parameter int NUM_BUF = 4);
   localparam int PW = $clog2(NUM_BUF);
   logic             trig_i;
   logic             disable_i;
   logic             clr_evt_i;
   logic             clr_all_i;
   logic [NUM_BUF-1:0] hold_o;
   logic             trig_ack_o;
   logic [PW-1:0]    trig_buf_o;
   logic             full_o;
   logic             busy_o;
   logic [PW:0]      nheld_o;
   logic [CNT_W-1:0] lost_o;
   logic [CNT_W-1:0] deadtime_o;
   modport master (output trig_i, disable_i, clr_evt_i, clr_all_i,
                   input hold_o, trig_ack_o, trig_buf_o, full_o, busy_o, nheld_o, lost_o, deadtime_o);
   modport slave  (input trig_i, disable_i, clr_evt_i, clr_all_i,
                   output hold_o, trig_ack_o, trig_buf_o, full_o, busy_o, nheld_o, lost_o, deadtime_o);
endinterface

// File: rtl/turf_hold_buffer_scheduler_buf_ring.sv
// turf_buf_ring: FIFO-ordered buffer ring with write/read pointers and the HOLD bit-vector
module turf_buf_ring #(
   parameter int NUM_BUF = 4,
   localparam int PW = $clog2(NUM_BUF)
) (
   input  logic               clk_i,
   input  logic               nrst_i,
   input  logic               set,
   input  logic               rel,
   input  logic               flush,
   output logic [NUM_BUF-1:0] hold,
   output logic [PW-1:0]      wr_idx,
   output logic [PW:0]        nheld,
   output logic               full
);
   logic [PW:0] wr, rd;
   logic rel_ok;
   assign nheld  = wr - rd;
   assign full   = nheld == (PW+1)'(NUM_BUF);
   assign wr_idx = wr[PW-1:0];
   assign rel_ok = rel & (nheld != '0);
   // allocate at wr, release oldest at rd; both may happen in the same cycle
   always_ff @(posedge clk_i or negedge nrst_i)
      if (!nrst_i || flush) begin
         wr   <= '0;
         rd   <= '0;
         hold <= '0;
      end else begin
         wr   <= wr + (PW+1)'(set);
         rd   <= rd + (PW+1)'(rel_ok);
         hold <= (hold & ~(rel_ok ? NUM_BUF'(1) << rd[PW-1:0] : '0))
               | (set ? NUM_BUF'(1) << wr[PW-1:0] : '0);
      end
endmodule

// File: rtl/turf_hold_buffer_scheduler.sv
// turf_hold_buffer_scheduler: trigger-to-HOLD buffer allocator; TURF_HOLD_DEADTIME_EN enables the deadtime counter
module turf_hold_buffer_scheduler
   import turf_hold_buffer_scheduler_pkg::*;
#(
   parameter int NUM_BUF    = 4,
   parameter int SETTLE_CYC = 8
) (
   input logic clk_i,
   input logic nrst_i,
   turf_hold_buffer_scheduler_if.slave bus
);
   localparam int PW = $clog2(NUM_BUF);
   state_t state, state_n;
   logic [7:0] settle_cnt;
   logic trig_v, full_q, accept, drop, full, ack;
   logic [PW-1:0] wr_idx, trig_buf;
   logic [PW:0] nheld;
   logic [NUM_BUF-1:0] hold;
   logic [CNT_W-1:0] lost;
   // trigger is judged one cycle after arrival against the full flag seen on arrival
   assign accept = trig_v & (state == IDLE) & ~full_q & ~bus.clr_all_i;
   assign drop   = trig_v & ((state != IDLE) | full_q);
   turf_buf_ring #(.NUM_BUF(NUM_BUF)) u_ring (
      .clk_i(clk_i), .nrst_i(nrst_i), .set(accept), .rel(bus.clr_evt_i), .flush(bus.clr_all_i),
      .hold(hold), .wr_idx(wr_idx), .nheld(nheld), .full(full)
   );
   // next-state: ISSUE lasts one cycle, SETTLE lasts SETTLE_CYC cycles
   always_comb begin
      state_n = state;
      state_n = (state == IDLE)  ? (accept ? ISSUE : IDLE) :
                (state == ISSUE) ? SETTLE :
                (settle_cnt == 8'(SETTLE_CYC - 1)) ? IDLE : SETTLE;
   end
   // state, input capture, ack/buffer outputs and lost-trigger counter
   always_ff @(posedge clk_i or negedge nrst_i)
      if (!nrst_i) begin
         state      <= IDLE;
         settle_cnt <= '0;
         trig_v     <= 1'b0;
         full_q     <= 1'b0;
         ack        <= 1'b0;
         trig_buf   <= '0;
         lost       <= '0;
      end else if (bus.clr_all_i) begin
         state      <= IDLE;
         settle_cnt <= '0;
         trig_v     <= 1'b0;
         full_q     <= 1'b0;
         ack        <= 1'b0;
         lost       <= '0;
      end else begin
         state      <= state_n;
         settle_cnt <= (state == SETTLE) ? settle_cnt + 8'd1 : 8'd0;
         trig_v     <= bus.trig_i & ~bus.disable_i;
         full_q     <= full;
         ack        <= accept;
         trig_buf   <= accept ? wr_idx : trig_buf;
         lost       <= drop ? sat_inc(lost) : lost;
      end
`ifdef TURF_HOLD_DEADTIME_EN
   logic [CNT_W-1:0] dead;
   // count cycles spent with every buffer held
   always_ff @(posedge clk_i or negedge nrst_i)
      if (!nrst_i || bus.clr_all_i) dead <= '0;
      else if (full) dead <= sat_inc(dead);
   assign bus.deadtime_o = dead;
`else
   assign bus.deadtime_o = '0;
`endif
   assign bus.hold_o     = hold;
   assign bus.trig_ack_o = ack;
   assign bus.trig_buf_o = trig_buf;
   assign bus.full_o     = full;
   assign bus.busy_o     = state != IDLE;
   assign bus.nheld_o    = nheld;
   assign bus.lost_o     = lost;
endmodule

// File: tb/tb_turf_hold_buffer_scheduler.sv
// tb_turf_hold_buffer_scheduler: directed and randomized checks against a queue/timestamp reference model
module tb_turf_hold_buffer_scheduler;
   localparam int NB = 4;
   localparam int S  = 8;
   logic clk = 0;
   logic nrst = 0;
   int n_cmp = 0;
   int n_bad = 0;
   turf_hold_buffer_scheduler_if #(.NUM_BUF(NB)) bus();
   turf_hold_buffer_scheduler #(.NUM_BUF(NB), .SETTLE_CYC(S)) dut (.clk_i(clk), .nrst_i(nrst), .bus(bus));
   always #5 clk = ~clk;

   int q[$];
   int nxt = 0, busy_until = 0, cyc = 0, lost_m = 0, dead_m = 0, buf_m = 0;
   bit pv = 0, pfull = 0, ack_m = 0;

   function automatic logic [NB-1:0] hold_of();
      logic [NB-1:0] h = '0;
      foreach (q[i]) h[q[i]] = 1'b1;
      return h;
   endfunction

   // apply one cycle of inputs, advance DUT and model, land 1 time unit after the edge
   task automatic step(input bit t, input bit d, input bit ce, input bit ca);
      bit acc, full_now;
      bus.trig_i = t; bus.disable_i = d; bus.clr_evt_i = ce; bus.clr_all_i = ca;
      @(posedge clk);
      full_now = (q.size() == NB);
      if (ca) begin
         q.delete(); nxt = 0; lost_m = 0; dead_m = 0; pv = 0; pfull = 0; ack_m = 0; busy_until = cyc + 1;
      end else begin
`ifdef TURF_HOLD_DEADTIME_EN
         if (full_now && dead_m < 65535) dead_m++;
`endif
         acc = pv && (cyc >= busy_until) && !pfull;
         if (pv && !acc && lost_m < 65535) lost_m++;
         if (ce && q.size() > 0) void'(q.pop_front());
         if (acc) begin
            q.push_back(nxt); buf_m = nxt; nxt = (nxt + 1) % NB; busy_until = cyc + 2 + S;
         end
         ack_m = acc;
         pv = t && !d;
         pfull = full_now;
      end
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   task automatic fill();
      for (int i = 0; i < 3; i++) begin step(1, 0, 0, 0); idle(11); end
      step(1, 0, 0, 0); idle(1);
   endtask

   task automatic test_reset();
      bus.trig_i = 0; bus.disable_i = 0; bus.clr_evt_i = 0; bus.clr_all_i = 0;
      repeat (3) @(posedge clk);
      #1 nrst = 1;
      idle(10);
      n_cmp++; if (bus.hold_o !== 4'b0) begin n_bad++; $display("FAIL reset_hold got %b want 0", bus.hold_o); end
      n_cmp++; if (bus.trig_ack_o !== 1'b0 || bus.trig_buf_o !== 2'd0) begin n_bad++; $display("FAIL reset_ack got %b/%0d want 0/0", bus.trig_ack_o, bus.trig_buf_o); end
      n_cmp++; if (bus.full_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.nheld_o !== 3'd0) begin n_bad++; $display("FAIL reset_status got %b%b%0d want 000", bus.full_o, bus.busy_o, bus.nheld_o); end
      n_cmp++; if (bus.lost_o !== 16'd0 || bus.deadtime_o !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got %0d/%0d want 0/0", bus.lost_o, bus.deadtime_o); end
   endtask

   task automatic test_single();
      int busy_n = 0;
      step(1, 0, 0, 0);
      n_cmp++; if (bus.hold_o !== 4'b0) begin n_bad++; $display("FAIL single_early got %b want 0000", bus.hold_o); end
      idle(1);
      n_cmp++; if (bus.hold_o !== 4'b0001 || bus.trig_ack_o !== 1'b1 || bus.trig_buf_o !== 2'd0) begin n_bad++; $display("FAIL single_hold got %b/%b/%0d want 0001/1/0", bus.hold_o, bus.trig_ack_o, bus.trig_buf_o); end
      for (int i = 0; i < 30; i++) begin busy_n += bus.busy_o; idle(1); end
      n_cmp++; if (busy_n != 1 + S) begin n_bad++; $display("FAIL single_busy got %0d want %0d", busy_n, 1 + S); end
   endtask

   task automatic test_fill();
      step(0, 0, 0, 1);
      for (int i = 0; i < 5; i++) begin step(1, 0, 0, 0); idle(19); end
      n_cmp++; if (bus.hold_o !== 4'b1111 || bus.full_o !== 1'b1) begin n_bad++; $display("FAIL fill_hold got %b/%b want 1111/1", bus.hold_o, bus.full_o); end
      n_cmp++; if (bus.lost_o !== 16'd1) begin n_bad++; $display("FAIL fill_lost got %0d want 1", bus.lost_o); end
   endtask

   task automatic test_clr_same();
      step(1, 0, 1, 0); idle(19);
      n_cmp++; if (bus.hold_o !== 4'b1110 || bus.lost_o !== 16'd2 || bus.nheld_o !== 3'd3) begin n_bad++; $display("FAIL clrsame got %b/%0d/%0d want 1110/2/3", bus.hold_o, bus.lost_o, bus.nheld_o); end
      step(1, 0, 0, 0); idle(1);
      n_cmp++; if (bus.hold_o !== 4'b1111 || bus.trig_ack_o !== 1'b1 || bus.trig_buf_o !== 2'd0) begin n_bad++; $display("FAIL wrap got %b/%b/%0d want 1111/1/0", bus.hold_o, bus.trig_ack_o, bus.trig_buf_o); end
      idle(12);
   endtask

   task automatic test_settle_drop();
      int acks = 0;
      step(0, 0, 0, 1);
      step(1, 0, 0, 0); idle(2); step(1, 0, 0, 0); idle(15);
      n_cmp++; if (bus.lost_o !== 16'd1 || bus.hold_o !== 4'b0001) begin n_bad++; $display("FAIL settle_drop got %0d/%b want 1/0001", bus.lost_o, bus.hold_o); end
      step(1, 1, 0, 0);
      for (int i = 0; i < 15; i++) begin acks += bus.trig_ack_o; idle(1); end
      n_cmp++; if (acks != 0 || bus.lost_o !== 16'd1) begin n_bad++; $display("FAIL disable got acks %0d lost %0d want 0/1", acks, bus.lost_o); end
   endtask

   task automatic test_clr_all();
      step(0, 0, 0, 1);
      for (int i = 0; i < 2; i++) begin step(1, 0, 0, 0); idle(11); end
      step(1, 0, 0, 0); idle(4);
      n_cmp++; if (bus.busy_o !== 1'b1 || bus.nheld_o !== 3'd3) begin n_bad++; $display("FAIL pre_clrall got %b/%0d want 1/3", bus.busy_o, bus.nheld_o); end
      step(0, 0, 0, 1);
      n_cmp++; if (bus.hold_o !== 4'b0 || bus.busy_o !== 1'b0 || bus.nheld_o !== 3'd0 || bus.lost_o !== 16'd0 || bus.deadtime_o !== 16'd0) begin n_bad++; $display("FAIL clrall got %b/%b/%0d/%0d want 0000/0/0/0", bus.hold_o, bus.busy_o, bus.nheld_o, bus.lost_o); end
      step(0, 0, 1, 0);
      n_cmp++; if (bus.hold_o !== 4'b0 || bus.nheld_o !== 3'd0 || bus.full_o !== 1'b0) begin n_bad++; $display("FAIL empty_clr got %b/%0d want 0000/0", bus.hold_o, bus.nheld_o); end
   endtask

   task automatic test_deadtime();
      logic [15:0] exp;
`ifdef TURF_HOLD_DEADTIME_EN
      exp = 16'd100;
`else
      exp = 16'd0;
`endif
      step(0, 0, 0, 1);
      fill();
      idle(100);
      n_cmp++; if (bus.deadtime_o !== exp) begin n_bad++; $display("FAIL deadtime got %0d want %0d", bus.deadtime_o, exp); end
   endtask

   task automatic test_lost_sat();
      step(0, 0, 0, 1);
      fill();
      for (int i = 0; i < 65540; i++) step(1, 0, 0, 0);
      idle(2);
      n_cmp++; if (bus.lost_o !== 16'hFFFF) begin n_bad++; $display("FAIL lost_sat got %h want ffff", bus.lost_o); end
      step(1, 0, 0, 0); idle(2);
      n_cmp++; if (bus.lost_o !== 16'hFFFF) begin n_bad++; $display("FAIL lost_stay got %h want ffff", bus.lost_o); end
   endtask

   task automatic test_random();
      step(0, 0, 0, 1);
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 12, $urandom_range(0, 999) < 8);
         n_cmp++; if (bus.hold_o !== hold_of()) begin n_bad++; $display("FAIL rnd_hold got %b want %b", bus.hold_o, hold_of()); end
         n_cmp++; if (bus.trig_ack_o !== ack_m || bus.trig_buf_o !== 2'(buf_m)) begin n_bad++; $display("FAIL rnd_ack got %b/%0d want %b/%0d", bus.trig_ack_o, bus.trig_buf_o, ack_m, buf_m); end
         n_cmp++; if (bus.nheld_o !== 3'(q.size()) || bus.full_o !== (q.size() == NB)) begin n_bad++; $display("FAIL rnd_occ got %0d/%b want %0d", bus.nheld_o, bus.full_o, q.size()); end
         n_cmp++; if (bus.busy_o !== (cyc < busy_until)) begin n_bad++; $display("FAIL rnd_busy got %b want %b", bus.busy_o, cyc < busy_until); end
         n_cmp++; if (bus.lost_o !== 16'(lost_m) || bus.deadtime_o !== 16'(dead_m)) begin n_bad++; $display("FAIL rnd_cnt got %0d/%0d want %0d/%0d", bus.lost_o, bus.deadtime_o, lost_m, dead_m); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_clr_same();
      test_settle_drop();
      test_clr_all();
      test_random();
      test_deadtime();
      test_lost_sat();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
